// File: rtl/sseg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_scan_mux
//  Description : Time-multiplexed seven-segment display scanner. Walks the
//                digits one slot at a time, applies per-digit blanking,
//                blinking and a 16-level brightness PWM, and drives
//                registered active-low anode and segment lines.
//  Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_mux #(
    parameter int DIGITS       = 4,
    parameter int SLOT_CYCLES  = 65536,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   hex_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank,
    input  logic [DIGITS-1:0]     blink,
    input  logic [3:0]            bright,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            sseg,
    output logic                  frame_tick
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int SLOT_W = $clog2(SLOT_CYCLES);
    localparam int DIG_W  = $clog2(DIGITS);
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Cycles per brightness step: a slot is split into 16 equal PWM steps.
    localparam int PWM_STEP = SLOT_CYCLES / 16;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    // Elaboration-time guard against illegal parameter combinations.
    generate
        if ((DIGITS < 2) || (DIGITS > 8)) begin : g_bad_digits
            $error("sseg_scan_mux: DIGITS must be in 2..8");
        end
        if ((SLOT_CYCLES < 16) || ((SLOT_CYCLES % 16) != 0)) begin : g_bad_slot
            $error("sseg_scan_mux: SLOT_CYCLES must be a multiple of 16, >= 16");
        end
        if (BLINK_FRAMES < 1) begin : g_bad_blink
            $error("sseg_scan_mux: BLINK_FRAMES must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [SLOT_W-1:0] slot_q,  slot_d;
    logic [DIG_W-1:0]  digit_q, digit_d;
    logic [FRM_W-1:0]  frame_q, frame_d;
    logic              phase_q, phase_d;

    // Output registers
    logic [DIGITS-1:0] an_q,   an_d;
    logic [7:0]        sseg_q, sseg_d;
    logic              tick_q, tick_d;

    // Per-digit nibbles split out of the packed input bus
    logic [3:0] w_nib [DIGITS];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = hex_in[4*gi +: 4];
        end
    endgenerate

    // Full-hex decode to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state for the slot / digit / frame / blink-phase counter chain.
    always_comb begin
        slot_d  = slot_q + 1'b1;
        digit_d = digit_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (slot_q == SLOT_LAST) begin
            slot_d = '0;
            if (digit_q == DIG_LAST) begin
                digit_d = '0;
                if (frame_q == FRM_LAST) begin
                    frame_d = '0;
                    phase_d = ~phase_q;
                end else begin
                    frame_d = frame_q + 1'b1;
                end
            end else begin
                digit_d = digit_q + 1'b1;
            end
        end
    end

    // Counter chain register; reset restarts the scan at slot 0 of digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q  <= '0;
            digit_q <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            digit_q <= digit_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from the current scan state and live inputs
    // ------------------------------------------------------------------------
    logic [SLOT_W:0] w_on_cycles;
    logic            w_pwm_on;
    logic            w_dark;

    // Lit window is (bright+1) PWM steps from the start of the slot; bright
    // is read live so a brightness change applies on the very next cycle.
    assign w_on_cycles = (SLOT_W + 1)'({1'b0, bright} + 5'd1) * (SLOT_W + 1)'(PWM_STEP);
    assign w_pwm_on    = ({1'b0, slot_q} < w_on_cycles);
    assign w_dark      = blank[digit_q] | (blink[digit_q] & phase_q) | ~w_pwm_on;

    // Build the next anode / segment / frame-tick values.
    always_comb begin
        an_d   = '1;
        sseg_d = 8'hFF;
        tick_d = (slot_q == '0) && (digit_q == '0);
        if (!w_dark) begin
            an_d   = ~(DIGITS'(1) << digit_q);
            sseg_d = {~dp_in[digit_q], hex_to_seg(w_nib[digit_q])};
        end
    end

    // Output register; reset forces the display dark with no tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q   <= '1;
            sseg_q <= 8'hFF;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            sseg_q <= sseg_d;
            tick_q <= tick_d;
        end
    end

    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sseg_scan_mux
//  Description : Self-checking bench for sseg_scan_mux (4 digits, 16-cycle
//                slots, 2-frame blink half-period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_mux;

    localparam int DIGITS       = 4;
    localparam int SLOT_CYCLES  = 16;
    localparam int BLINK_FRAMES = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [4*DIGITS-1:0] hex_in;
    logic [DIGITS-1:0]   dp_in, blank, blink;
    logic [3:0]          bright;
    logic [DIGITS-1:0]   an;
    logic [7:0]          sseg;
    logic                frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sseg_scan_mux #(
        .DIGITS      (DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .hex_in    (hex_in),
        .dp_in     (dp_in),
        .blank     (blank),
        .blink     (blink),
        .bright    (bright),
        .an        (an),
        .sseg      (sseg),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, got, exp);
        end
    endtask

    // Reference seven-segment patterns, active low {g..a}.
    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001;
        seg_tab[14] = 7'b0000110; seg_tab[15] = 7'b0001110;
    end

    // Model: output cycle n after reset release shows slot n%16 of digit
    // (n/16)%4, in frame n/64; blink phase flips every 2 frames.
    initial begin : model_cmp
        int         n;
        bit         valid;
        int         slot, dig, ph;
        bit         lit;
        logic [3:0] e_an;
        logic [7:0] e_ss;
        logic       e_tk;
        logic [3:0] nib;
        n = 0; valid = 0;
        e_an = '1; e_ss = 8'hFF; e_tk = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                e_an = 4'hF; e_ss = 8'hFF; e_tk = 1'b0;
                n = 0; valid = 1;
            end else if (valid) begin
                slot = n % SLOT_CYCLES;
                dig  = (n / SLOT_CYCLES) % DIGITS;
                ph   = (n / (SLOT_CYCLES * DIGITS * BLINK_FRAMES)) % 2;
                lit  = !blank[dig] && !(blink[dig] && ph == 1)
                       && (slot < (int'(bright) + 1) * SLOT_CYCLES / 16);
                e_tk = (n % (SLOT_CYCLES * DIGITS)) == 0;
                if (lit) begin
                    e_an = 4'hF;
                    e_an[dig] = 1'b0;
                    nib  = hex_in[4*dig +: 4];
                    e_ss = {~dp_in[dig], seg_tab[nib]};
                end else begin
                    e_an = 4'hF;
                    e_ss = 8'hFF;
                end
                n++;
            end
            @(negedge clk);
            if (valid) begin
                chk("model an", {28'd0, an}, {28'd0, e_an});
                chk("model sseg", {24'd0, sseg}, {24'd0, e_ss});
                chk("model frame_tick", {31'd0, frame_tick}, {31'd0, e_tk});
                chk("one-hot an", $countones(~an) <= 1, 1);
            end
        end
    end

    task automatic adv(input int k);
        repeat (k) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Advance to output cycle c (relative to last restart).
    task automatic go(input int c);
        adv(c - cyc);
    endtask

    task automatic lit_chk(input string nm, input logic [3:0] ea, input logic [7:0] es, input logic et);
        chk({nm, " an"}, {28'd0, an}, {28'd0, ea});
        chk({nm, " sseg"}, {24'd0, sseg}, {24'd0, es});
        chk({nm, " tick"}, {31'd0, frame_tick}, {31'd0, et});
    endtask

    // One-cycle reset, then position on output cycle 0.
    task automatic restart;
        reset = 1'b1;
        @(negedge clk);
        lit_chk("reset dark", 4'hF, 8'hFF, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        cyc = 0;
    endtask

    initial begin
        reset  = 1'b1;
        hex_in = 16'h3210;
        dp_in  = '0;
        blank  = '0;
        blink  = '0;
        bright = 4'd15;

        // Held reset: dark, no tick
        repeat (3) begin
            @(negedge clk);
            lit_chk("held reset", 4'hF, 8'hFF, 1'b0);
        end

        // Full brightness scan
        reset = 1'b0;
        @(negedge clk);
        cyc = 0;
        lit_chk("d0 first", 4'hE, 8'hC0, 1'b1);
        go(15); lit_chk("d0 last", 4'hE, 8'hC0, 1'b0);
        go(16); lit_chk("d1", 4'hD, 8'hF9, 1'b0);
        go(32); lit_chk("d2", 4'hB, 8'hA4, 1'b0);
        go(48); lit_chk("d3", 4'h7, 8'hB0, 1'b0);
        go(64); lit_chk("frame2", 4'hE, 8'hC0, 1'b1);
        go(70);

        // Brightness 3: 4 lit, 12 dark per slot
        bright = 4'd3;
        restart();
        go(3);  lit_chk("pwm on end", 4'hE, 8'hC0, 1'b1 & (cyc == 0));
        go(4);  lit_chk("pwm off", 4'hF, 8'hFF, 1'b0);
        go(19); lit_chk("pwm d1 on", 4'hD, 8'hF9, 1'b0);
        go(20); lit_chk("pwm d1 off", 4'hF, 8'hFF, 1'b0);
        go(64);

        // Blink digit 0
        bright = 4'd15;
        blink  = 4'b0001;
        restart();
        go(128); lit_chk("blink dark", 4'hF, 8'hFF, 1'b1);
        go(144); lit_chk("blink d1", 4'hD, 8'hF9, 1'b0);
        go(256); lit_chk("blink relit", 4'hE, 8'hC0, 1'b1);
        go(260);

        // Blank digit 1, decimal point on digit 2
        blink = '0;
        blank = 4'b0010;
        dp_in = 4'b0100;
        restart();
        lit_chk("dp d0", 4'hE, 8'hC0, 1'b1);
        go(16); lit_chk("blank d1", 4'hF, 8'hFF, 1'b0);
        go(32); lit_chk("dp d2", 4'hB, 8'h24, 1'b0);
        go(66);

        // Live input changes each cycle
        blank = '0;
        dp_in = '0;
        restart();
        repeat (140) begin
            hex_in = 16'($urandom);
            dp_in  = 4'($urandom);
            blank  = 4'($urandom) & 4'($urandom);
            blink  = 4'($urandom);
            bright = 4'($urandom);
            adv(1);
        end

        // Reset in the middle of a blink-dark phase, during digit 2's slot
        hex_in = 16'h3210; dp_in = '0; blank = '0; bright = 4'd15;
        blink  = 4'b0001;
        restart();
        go(128 + 32 + 5);
        lit_chk("pre-reset d2", 4'hB, 8'hA4, 1'b0);
        restart();
        lit_chk("resume d0", 4'hE, 8'hC0, 1'b1);
        go(15); lit_chk("resume d0 end", 4'hE, 8'hC0, 1'b0);
        go(16); lit_chk("resume d1", 4'hD, 8'hF9, 1'b0);
        go(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sseg_scan_mux.md
SSEG_SCAN_MUX -- requirements
Module: sseg_scan_mux

Interface
REQ-001 The block SHALL provide parameter DIGITS, default 4, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The block SHALL provide parameter SLOT_CYCLES, default 65536, giving clock cycles per digit slot (a multiple of 16, at least 16).
REQ-003 The block SHALL provide parameter BLINK_FRAMES, default 64, giving full scan frames per blink half-period (at least 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port hex_in, input, 4*DIGITS bits: digit i value at [4i+3:4i].
REQ-007 The block SHALL have port dp_in, input, DIGITS bits: bit i=1 lights the decimal point of digit i.
REQ-008 The block SHALL have port blank, input, DIGITS bits: bit i=1 keeps digit i dark.
REQ-009 The block SHALL have port blink, input, DIGITS bits: bit i=1 makes digit i blink.
REQ-010 The block SHALL have port bright, input, 4 bits: duty level, 0=1/16 on, 15=16/16 on.
REQ-011 The block SHALL have port an, output, DIGITS bits: registered, active-low, one-hot-low digit enable.
REQ-012 The block SHALL have port sseg, output, 8 bits: registered, active-low; [6:0]={g,f,e,d,c,b,a}, [7]=dp.
REQ-013 The block SHALL have port frame_tick, output, 1 bit: registered one-cycle pulse at each frame start.

Function
REQ-014 A slot counter SHALL count 0..SLOT_CYCLES-1 and wrap to 0; on wrap a digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-015 When digit index wraps DIGITS-1->0, a frame counter SHALL advance 0..BLINK_FRAMES-1; on its wrap, blink_phase SHALL toggle.
REQ-016 an, sseg and frame_tick SHALL be registered, with one cycle of latency from the counter state and live inputs.
REQ-017 The selected digit i SHALL be lit when slot count < (bright+1)*SLOT_CYCLES/16, using live bright.
REQ-018 Dark priority SHALL be: blank[i] first, then blink[i] AND blink_phase, then PWM off-time.
REQ-019 A dark slot cycle SHALL drive an all ones and sseg 8'hFF.
REQ-020 When lit, an SHALL drive bit i low and all other bits high.
REQ-021 When lit, sseg[7] SHALL equal ~dp_in[i].
REQ-022 When lit, sseg[6:0] SHALL use the full-hex decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-023 frame_tick SHALL be high exactly in the output cycle that drives the first cycle of digit 0's slot, including the first slot after reset.
REQ-024 Input changes SHALL take effect on the next output cycle, with no snapshot and no glitch beyond one cycle.
REQ-025 More than one an bit SHALL never be low in the same cycle.

Reset
REQ-026 While reset is high, the block SHALL hold the slot counter, digit index and frame counter at 0 and blink_phase at 0.
REQ-027 While reset is high, an SHALL be all ones, sseg SHALL be 8'hFF and frame_tick SHALL be 0.
REQ-028 On the first edge with reset low, outputs SHALL present slot 0 of digit 0 with frame_tick=1.
REQ-029 Reset asserted mid-slot or mid-frame SHALL abort the scan on the next edge; there SHALL be no partial slot on resume.

Verification (DIGITS=4, SLOT_CYCLES=16, BLINK_FRAMES=2)
REQ-030 Reset held 3 cycles -> an=4'hF, sseg=8'hFF, frame_tick=0 throughout.
REQ-031 hex_in=16'h3210, bright=15, dp_in=0, blank=0, blink=0 -> an=1110/sseg=C0 for 16 cycles, then 1101/F9, then 1011/A4, then 0111/B0; frame_tick pulses every 64 cycles.
REQ-032 bright=3 -> each slot lit for 4 cycles, then dark (an=F, sseg=FF) for 12 cycles.
REQ-033 blink=4'b0001 -> digit 0 lit in frames 0-1 and dark in frames 2-3, repeating every 4 frames; digits 1-3 unaffected.
REQ-034 blank=4'b0010, dp_in=4'b0100 -> an[1] never low; during digit 2 slot sseg[7]=0; other slots sseg[7]=1.
REQ-035 reset pulsed 1 cycle during digit 2 slot -> next cycle an=F, sseg=FF; after release, full 16-cycle digit 0 slot with frame_tick=1 and blink_phase=0.
